// File: rtl/load_unit.sv
// load_unit: sequential load unit between the core and the data-memory bus.
// Takes one load request at a time, issues one or two aligned bus reads,
// extracts the addressed bytes and returns a sign- or zero-extended result
// on a valid/ready response port.
module load_unit #(
    parameter int XLEN       = 32,
    parameter bit MISALIGNED = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [31:0]     req_addr,
    input  logic [2:0]      req_funct3,
    input  logic [4:0]      req_rd,
    output logic            mem_valid,
    input  logic            mem_ready,
    output logic [31:0]     mem_addr,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_data,
    output logic [4:0]      rsp_rd,
    output logic            rsp_fault
);

    localparam int NB = XLEN / 8;
    localparam int OB = $clog2(NB);

    typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;

    state_t state, state_next;

    logic [31:0]     addr_reg;
    logic [2:0]      funct3_reg;
    logic [4:0]      rd_reg;
    logic            cross_reg;
    logic [XLEN-1:0] beat0_reg;
    logic [XLEN-1:0] data_reg;
    logic            fault_reg;

    // ---------------------------------------------------------------
    // Request decode (only meaningful while IDLE, used at accept)
    // ---------------------------------------------------------------
    logic [3:0]    req_size;
    logic [3:0]    req_mask;
    logic [OB-1:0] req_off;
    logic          req_illegal;
    logic          req_misaligned;
    logic          req_cross;
    logic          req_fault;
    logic          accept;

    assign req_size       = 4'd1 << req_funct3[1:0];
    assign req_mask       = req_size - 4'd1;
    assign req_off        = req_addr[OB-1:0];
    assign req_illegal    = (req_funct3 == 3'b111) ||
                            ((XLEN == 32) && ((req_funct3 == 3'b011) || (req_funct3 == 3'b110)));
    assign req_misaligned = (req_addr[3:0] & req_mask) != 4'd0;
    assign req_cross      = (5'(req_off) + 5'(req_size)) > 5'(NB);
    assign req_fault      = req_illegal || (req_misaligned && !MISALIGNED);
    assign accept         = req_valid && (state == IDLE);

    // ---------------------------------------------------------------
    // Extraction: merge beats, shift down by the byte offset, extend.
    // In WAIT0 the live bus data is the only beat; in WAIT1 it is the
    // upper beat and beat0 supplies the lower bytes.
    // ---------------------------------------------------------------
    logic [2*XLEN-1:0] merged;
    logic [XLEN-1:0]   shifted;
    logic [XLEN-1:0]   ext_data;
    logic [6:0]        ext_bits;
    logic              sign_ext;
    logic              top_bit;
    logic [31:0]       word_addr;

    assign merged    = (state == WAIT1) ? {mem_rdata, beat0_reg} : {{XLEN{1'b0}}, mem_rdata};
    assign shifted   = XLEN'(merged >> {addr_reg[OB-1:0], 3'b000});
    assign ext_bits  = 7'd8 << funct3_reg[1:0];
    assign sign_ext  = !funct3_reg[2] && (funct3_reg[1:0] != 2'b11);
    assign word_addr = {addr_reg[31:OB], {OB{1'b0}}};

    // Pick the top extracted bit for the current access size
    always_comb begin
        top_bit = 1'b0;
        case (funct3_reg[1:0])
            2'b00:   top_bit = shifted[7];
            2'b01:   top_bit = shifted[15];
            2'b10:   top_bit = shifted[31];
            default: top_bit = shifted[XLEN-1];
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < XLEN; gi++) begin : g_ext
            assign ext_data[gi] = (ext_bits > 7'(gi)) ? shifted[gi] : (sign_ext & top_bit);
        end
    endgenerate

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and handshake outputs
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        mem_valid  = 1'b0;
        mem_addr   = 32'd0;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = req_fault ? RESP : REQ0;
                end
            end
            REQ0: begin
                mem_valid = 1'b1;
                mem_addr  = word_addr;
                if (mem_ready) begin
                    state_next = WAIT0;
                end
            end
            WAIT0: begin
                if (mem_rvalid) begin
                    state_next = cross_reg ? REQ1 : RESP;
                end
            end
            REQ1: begin
                mem_valid = 1'b1;
                mem_addr  = word_addr + 32'(NB);
                if (mem_ready) begin
                    state_next = WAIT1;
                end
            end
            WAIT1: begin
                if (mem_rvalid) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Request latch, beat capture and registered response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg   <= '0;
            funct3_reg <= '0;
            rd_reg     <= '0;
            cross_reg  <= 1'b0;
            beat0_reg  <= '0;
            data_reg   <= '0;
            fault_reg  <= 1'b0;
        end else begin
            if (accept) begin
                addr_reg   <= req_addr;
                funct3_reg <= req_funct3;
                rd_reg     <= req_rd;
                cross_reg  <= req_cross;
                beat0_reg  <= '0;
                data_reg   <= '0;
                fault_reg  <= req_fault;
            end
            if ((state == WAIT0) && mem_rvalid) begin
                beat0_reg <= mem_rdata;
                if (!cross_reg) begin
                    data_reg  <= ext_data;
                    fault_reg <= 1'b0;
                end
            end
            if ((state == WAIT1) && mem_rvalid) begin
                data_reg  <= ext_data;
                fault_reg <= 1'b0;
            end
        end
    end

    assign rsp_data  = data_reg;
    assign rsp_rd    = rd_reg;
    assign rsp_fault = fault_reg;

endmodule
